// File: rtl/wb_arena_switch_if.sv
// Bus bundle for wb_arena_switch: the master-side Wishbone signals plus the
// shared/per-slot slave-side signals. The switch uses the slave modport.
interface wb_arena_switch_if #(
   parameter int NSLV = 4,
   parameter int AW   = 19,
   parameter int DW   = 16
);
   logic [AW:1]      m_adr_i;
   logic [DW-1:0]    m_dat_i;
   logic [DW-1:0]    m_dat_o;
   logic             m_we_i;
   logic [DW/8-1:0]  m_sel_i;
   logic             m_tga_i;
   logic             m_stb_i;
   logic             m_cyc_i;
   logic             m_ack_o;
   logic [AW:1]      s_adr_o;
   logic [DW-1:0]    s_dat_o;
   logic             s_we_o;
   logic [DW/8-1:0]  s_sel_o;
   logic [NSLV-1:0]  s_stb_o;
   logic [NSLV-1:0]  s_cyc_o;
   logic [NSLV*DW-1:0] s_dat_i;
   logic [NSLV-1:0]  s_ack_i;

   modport slave (
      input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_tga_i, m_stb_i, m_cyc_i,
      input  s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o
   );

   modport master (
      output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_tga_i, m_stb_i, m_cyc_i,
      output s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o
   );
endinterface

// File: rtl/wb_arena_switch.sv
// Single-master, NSLV-slot Wishbone switch with base/mask decode, bus-timeout
// watchdog and master abort. Define WB_ARENA_ERRLOG_EN to add the timeout log.
module wb_arena_switch #(
   parameter int                 NSLV    = 4,
   parameter int                 AW      = 19,
   parameter int                 DW      = 16,
   parameter logic [NSLV*AW-1:0] BASE    = '0,
   parameter logic [NSLV*AW-1:0] MASK    = '0,
   parameter logic [NSLV-1:0]    IOSP    = '0,
   parameter logic [DW-1:0]      DEF_DAT = '0,
   parameter logic [DW-1:0]      ERR_DAT = '1,
   parameter int                 TO_CYC  = 255
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   wb_arena_switch_if.slave      bus,
   output logic                  err_o
`ifdef WB_ARENA_ERRLOG_EN
   ,
   output logic [AW:1]           err_adr_o,
   output logic                  err_tga_o,
   output logic                  err_sticky_o,
   input  logic                  err_clr_i
`endif
);
   localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, WAIT, ACK} state_t;

   state_t        state;
   logic [SW-1:0] sel;
   logic          mapped;
   logic [15:0]   timer;
   logic          hit;
   logic [SW-1:0] hit_idx;
   logic          to_ev;

   // Walk high-to-low so the lowest-index matching slot is the one kept.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NSLV - 1; k >= 0; k--) begin
         if ((((bus.m_adr_i ^ BASE[k*AW +: AW]) & MASK[k*AW +: AW]) == '0) &&
             (IOSP[k] == bus.m_tga_i)) begin
            hit     = 1'b1;
            hit_idx = SW'(k);
         end
      end
   end

   // Timeout fires on the cycle the timer would reach zero; a slave ack there wins.
   assign to_ev = (state == WAIT) && bus.m_cyc_i && !bus.s_ack_i[sel] && (timer == 16'd1);
   assign bus.s_cyc_o = bus.s_stb_o;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         sel         <= '0;
         mapped      <= 1'b0;
         timer       <= '0;
         bus.m_ack_o <= 1'b0;
         bus.m_dat_o <= '0;
         bus.s_adr_o <= '0;
         bus.s_dat_o <= '0;
         bus.s_we_o  <= 1'b0;
         bus.s_sel_o <= '0;
         bus.s_stb_o <= '0;
         err_o       <= 1'b0;
      end else begin
         bus.m_ack_o <= 1'b0;
         err_o       <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.m_cyc_i && bus.m_stb_i) begin
                  bus.s_adr_o <= bus.m_adr_i;
                  bus.s_dat_o <= bus.m_dat_i;
                  bus.s_we_o  <= bus.m_we_i;
                  bus.s_sel_o <= bus.m_sel_i;
                  sel         <= hit_idx;
                  mapped      <= hit;
                  state       <= DECODE;
               end
            end
            DECODE: begin
               if (!bus.m_cyc_i) begin
                  state <= IDLE;
               end else if (mapped) begin
                  bus.s_stb_o <= NSLV'(1) << sel;
                  timer       <= 16'(TO_CYC);
                  state       <= WAIT;
               end else begin
                  bus.m_dat_o <= DEF_DAT;
                  bus.m_ack_o <= 1'b1;
                  state       <= ACK;
               end
            end
            WAIT: begin
               timer <= timer - 16'd1;
               if (!bus.m_cyc_i) begin
                  bus.s_stb_o <= '0;
                  state       <= IDLE;
               end else if (bus.s_ack_i[sel]) begin
                  bus.m_dat_o <= bus.s_dat_i[sel*DW +: DW];
                  bus.s_stb_o <= '0;
                  bus.m_ack_o <= 1'b1;
                  state       <= ACK;
               end else if (to_ev) begin
                  bus.m_dat_o <= ERR_DAT;
                  bus.s_stb_o <= '0;
                  bus.m_ack_o <= 1'b1;
                  err_o       <= 1'b1;
                  state       <= ACK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_ARENA_ERRLOG_EN
   logic tga_q;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tga_q        <= 1'b0;
         err_adr_o    <= '0;
         err_tga_o    <= 1'b0;
         err_sticky_o <= 1'b0;
      end else begin
         if (state == IDLE && bus.m_cyc_i && bus.m_stb_i)
            tga_q <= bus.m_tga_i;
         // A fresh timeout outranks a clear in the same cycle.
         if (to_ev) begin
            err_adr_o    <= bus.s_adr_o;
            err_tga_o    <= tga_q;
            err_sticky_o <= 1'b1;
         end else if (err_clr_i) begin
            err_sticky_o <= 1'b0;
         end
      end
   end
`endif
endmodule
